neuron_mac_pe: RTL
==================

Name: neuron_mac_pe

Overview:
- Parametrised successor to the fixed per-layer neuron blocks.
- Computes one fully-connected neuron: NUM_LANES inputs per beat, multiplied by weights held in an internal, runtime-loadable weight memory.
- Accumulates with saturation, adds a runtime-loadable bias, then applies a selectable activation (identity or ReLU).
- Uses valid/ready handshakes on both the input stream and the output, so neurons can be chained with backpressure inside the layer datapath.

Parameters:
- LAYER_NO, 1, layer id matched against config_layer_num for weight/bias loading.
- NEURON_NO, 0, neuron id matched against config_neuron_num.
- NUM_WEIGHT, 784, weights per neuron; must be a multiple of NUM_LANES.
- NUM_LANES, 4, inputs and weights consumed per accepted beat.
- DATA_W, 16, signed input, weight, bias and output width.
- WEIGHT_INT_W, 1, integer bits of the fixed-point format Q(WEIGHT_INT_W).(DATA_W-WEIGHT_INT_W).

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- in_data  in  NUM_LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W]; signed.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- weight_valid  in  1  weight load strobe.
- weight_value  in  32  bits [DATA_W-1:0] are the weight.
- bias_valid  in  1  bias load strobe.
- bias_value  in  32  bits [DATA_W-1:0] are the bias, in the output format.
- config_layer_num  in  32  load target layer.
- config_neuron_num  in  32  load target neuron.
- act_mode  in  1  0 = identity, 1 = ReLU; sampled when the BIAS state is entered.
- out_data  out  DATA_W  activated neuron output.
- out_valid  out  1  output valid; held until out_ready.
- out_ready  in  1  downstream accept.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, bias=0, FSM=IDLE, load pointer=0, beat counter=0, accumulator=0. Weight memory contents are not reset.
- Weight load:
  - A weight is written when weight_valid=1 and config_layer_num==LAYER_NO and config_neuron_num==NEURON_NO.
  - Load pointer p selects lane p%NUM_LANES, word p/NUM_LANES; the pointer then increments.
  - The pointer wraps to 0 after NUM_WEIGHT-1.
  - Loads are accepted in any FSM state.
- Bias load: same id match with bias_valid=1 updates the bias register. If bias_valid and weight_valid are both high, both loads happen.
- FSM states IDLE, ACCUM, DRAIN, BIAS, ACT, OUT. BEATS = NUM_WEIGHT/NUM_LANES.
  - IDLE: in_ready=1. The first accepted beat moves to ACCUM and sets the beat counter to 1.
  - ACCUM: in_ready=1 while the beat counter < BEATS. Each accepted beat increments the counter. Acceptance of beat BEATS moves to DRAIN and drops in_ready on the next cycle.
  - DRAIN: wait until the 3-stage MAC pipe is empty, then go to BIAS.
  - BIAS: acc <= sat(acc + sext(bias) << (DATA_W-WEIGHT_INT_W)). One cycle.
  - ACT:
    - Extract y = acc[2*DATA_W-1-WEIGHT_INT_W -: DATA_W].
    - If the discarded upper bits are not a sign extension of y, clamp to 0x7FF..F or 0x800..0.
    - If act_mode=1 and the clamped result is negative, output 0.
    - Register into out_data and set out_valid. Go to OUT.
  - OUT: hold out_data and out_valid until out_ready=1. Then clear out_valid and the accumulator, reset the beat counter, and go to IDLE.
- MAC pipeline, for a beat accepted at cycle T:
  - T+1: weight word read (synchronous RAM) and input registered.
  - T+2: NUM_LANES signed products registered, each 2*DATA_W wide.
  - T+3: lane sum, full precision (2*DATA_W + clog2(NUM_LANES) bits).
  - T+4: acc <= sat_{2*DATA_W}(acc + lane sum).
- Latency: the last beat accepted at cycle T gives out_valid=1 at T+6 with back-to-back input and no stall. Gaps between input beats are allowed.
- Saturation: the accumulator and bias add clamp to the signed 2*DATA_W range. There is no wrap-around.
- Reset mid-operation: asserting rst asynchronously aborts any state, clears out_valid, and returns to IDLE. The loaded weights remain usable; the bias is cleared.
- A new computation cannot start until the output has been accepted. in_ready stays 0 in DRAIN, BIAS, ACT and OUT.

Test Plan:
Common configuration for all scenarios: NUM_LANES=2, NUM_WEIGHT=4, DATA_W=16, WEIGHT_INT_W=1, LAYER_NO=1, NEURON_NO=0.
1. Load 4 weights 0x4000 and bias 0x1000. Send 2 beats of {0x2000,0x2000} back-to-back -> out_data=0x5000 (0.625), out_valid rises 6 cycles after the 2nd acceptance.
2. Same weights and bias, inputs 0xE000 -> act_mode=0 gives 0xD000; act_mode=1 gives 0x0000.
3. Weights 0x7FFF, inputs 0x7FFF, bias 0x7FFF -> out_data=0x7FFF (positive clamp). Weights 0x7FFF, inputs 0x8000, bias 0x8000 -> 0x8000 (negative clamp).
4. Hold out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0 throughout. Then out_ready=1 -> out_valid=0 next cycle and in_ready=1.
5. Weight writes with config_neuron_num=1 must not alter results. Write 5 weights -> the 5th overwrites lane0/word0, verified by a recomputed output.
6. Deassert rst during DRAIN -> out_valid=0, busy=0 immediately. A following full computation with re-loaded bias gives the scenario-1 result.

Source files
------------

// File: rtl/neuron_mac_pe.sv
// rtl/neuron_mac_pe.sv - Fully-connected neuron PE: lane MAC, saturating accumulate, bias, activation.
module neuron_mac_pe #(
  parameter int LAYER_NO     = 1,
  parameter int NEURON_NO    = 0,
  parameter int NUM_WEIGHT   = 784,
  parameter int NUM_LANES    = 4,
  parameter int DATA_W       = 16,
  parameter int WEIGHT_INT_W = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_LANES*DATA_W-1:0]   in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          weight_valid,
  input  logic [31:0]                   weight_value,
  input  logic                          bias_valid,
  input  logic [31:0]                   bias_value,
  input  logic [31:0]                   config_layer_num,
  input  logic [31:0]                   config_neuron_num,
  input  logic                          act_mode,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy
);
  localparam int BEATS  = NUM_WEIGHT / NUM_LANES;
  localparam int ACC_W  = 2 * DATA_W;
  localparam int SUM_W  = ACC_W + $clog2(NUM_LANES);
  localparam int EXT_W  = SUM_W + 1;
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int ADDR_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = $clog2(BEATS + 1);
  localparam int FRAC_W = DATA_W - WEIGHT_INT_W;
  localparam int TOP    = ACC_W - 1 - WEIGHT_INT_W;
  localparam logic signed [EXT_W-1:0] ACC_MAX = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] ACC_MIN = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, BIAS, ACT, OUT} state_t;

  state_t                    state;
  logic                      accept;
  logic                      cfg_hit;
  logic [LANE_W-1:0]         ld_lane;
  logic [ADDR_W-1:0]         ld_word;
  logic signed [DATA_W-1:0]  bias_q;
  logic signed [EXT_W-1:0]   bias_sh;
  logic [CNT_W-1:0]          beat_cnt;
  logic signed [DATA_W-1:0]  wmem [NUM_LANES][BEATS];
  logic signed [DATA_W-1:0]  w_rd [NUM_LANES];
  logic signed [DATA_W-1:0]  x_q  [NUM_LANES];
  logic signed [ACC_W-1:0]   prod [NUM_LANES];
  logic signed [SUM_W-1:0]   sum_c;
  logic signed [SUM_W-1:0]   lane_sum;
  logic                      v1, v2, v3;
  logic signed [ACC_W-1:0]   acc;
  logic                      act_q;
  logic [DATA_W-1:0]         y;
  logic [ACC_W-TOP-1:0]      hi;
  logic [DATA_W-1:0]         clamped;
  logic [DATA_W-1:0]         act_out;
  logic                      unused_bits;

  assign accept      = in_valid && in_ready;
  assign cfg_hit     = (config_layer_num == 32'(LAYER_NO)) && (config_neuron_num == 32'(NEURON_NO));
  assign bias_sh     = EXT_W'(bias_q) <<< FRAC_W;
  assign unused_bits = ^{weight_value[31:DATA_W], bias_value[31:DATA_W]};

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [EXT_W-1:0] v);
    if (v > ACC_MAX)      sat_acc = ACC_MAX[ACC_W-1:0];
    else if (v < ACC_MIN) sat_acc = ACC_MIN[ACC_W-1:0];
    else                  sat_acc = v[ACC_W-1:0];
  endfunction

  // Load pointer is kept as (lane, word) so no divider is needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_lane <= '0;
      ld_word <= '0;
      bias_q  <= '0;
    end else begin
      if (bias_valid && cfg_hit) bias_q <= bias_value[DATA_W-1:0];
      if (weight_valid && cfg_hit) begin
        if (ld_lane == LANE_W'(NUM_LANES - 1)) begin
          ld_lane <= '0;
          ld_word <= (ld_word == ADDR_W'(BEATS - 1)) ? '0 : ld_word + 1'b1;
        end else begin
          ld_lane <= ld_lane + 1'b1;
        end
      end
    end
  end

  // Weight store is not reset; the read address is the index of the beat being accepted.
  always_ff @(posedge clk) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (weight_valid && cfg_hit && ld_lane == LANE_W'(l))
        wmem[l][ld_word] <= weight_value[DATA_W-1:0];
      w_rd[l] <= wmem[l][beat_cnt[ADDR_W-1:0]];
    end
  end

  always_comb begin
    sum_c = '0;
    for (int l = 0; l < NUM_LANES; l++) sum_c = sum_c + SUM_W'(prod[l]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      lane_sum <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        x_q[l]  <= '0;
        prod[l] <= '0;
      end
    end else begin
      v1       <= accept;
      v2       <= v1;
      v3       <= v2;
      lane_sum <= sum_c;
      for (int l = 0; l < NUM_LANES; l++) begin
        if (accept) x_q[l] <= in_data[l*DATA_W +: DATA_W];
        prod[l] <= ACC_W'(x_q[l]) * ACC_W'(w_rd[l]);
      end
    end
  end

  // Output slice with clamp when the dropped integer bits are not a sign extension.
  always_comb begin
    y  = acc[TOP -: DATA_W];
    hi = acc[ACC_W-1:TOP];
    if (&hi || !(|hi))     clamped = y;
    else if (acc[ACC_W-1]) clamped = {1'b1, {(DATA_W-1){1'b0}}};
    else                   clamped = {1'b0, {(DATA_W-1){1'b1}}};
    act_out = (act_q && clamped[DATA_W-1]) ? '0 : clamped;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      beat_cnt  <= '0;
      acc       <= '0;
      act_q     <= 1'b0;
    end else begin
      if (v3) acc <= sat_acc(EXT_W'(acc) + EXT_W'(lane_sum));
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            beat_cnt <= CNT_W'(1);
            busy     <= 1'b1;
            if (BEATS == 1) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == CNT_W'(BEATS - 1)) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // The last beat is in the adder stage, so acc is final when BIAS runs.
          if (!v1 && !v2) begin
            state <= BIAS;
            act_q <= act_mode;
          end
        end
        BIAS: begin
          acc   <= sat_acc(EXT_W'(acc) + bias_sh);
          state <= ACT;
        end
        ACT: begin
          out_data  <= act_out;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            beat_cnt  <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
